// File: rtl/conv3x3_pkg.sv
// ---------------------------------------------------------------------------
// conv3x3_pkg
// Shared types and helpers for the 3x3 streaming neighbourhood filter.
//   mode_e       kernel selection (LAP4, LAP8, SHARP, ALAP4)
//   ACC_GUARD_W  extra accumulator bits above the pixel width
//   clampPixel   folds a signed accumulator into the unsigned pixel range
// ---------------------------------------------------------------------------
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_LAP4  = 2'd0,
        MODE_LAP8  = 2'd1,
        MODE_SHARP = 2'd2,
        MODE_ALAP4 = 2'd3
    } mode_e;

    // 8C-N8 spans +/-8*(2^DATA_W-1), so 4 guard bits plus a sign bit suffice.
    localparam int ACC_GUARD_W = 5;

    // With useAbs the magnitude is taken first (saturate only); otherwise the
    // value is clamped to [0, maxVal].
    function automatic logic [31:0] clampPixel(
        input logic signed [31:0] value,
        input logic signed [31:0] maxVal,
        input logic               useAbs
    );
        logic signed [31:0] mag;
        mag = (useAbs && (value < 0)) ? -value : value;
        if (mag < 0)
            clampPixel = '0;
        else if (mag > maxVal)
            clampPixel = maxVal;
        else
            clampPixel = mag;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Two line-deep pixel store addressed by column. Reads are combinational at
// i_addr; on a write the older line takes the newer line's pixel and the
// newer line takes i_data, so each column shifts down by one row.
//   clk     clock, rising edge
//   i_we    write/shift enable (input pixel accepted)
//   i_addr  column address
//   i_data  incoming pixel (row r)
//   o_top   pixel at this column from row r-2
//   o_mid   pixel at this column from row r-1
// ---------------------------------------------------------------------------
module line_buffer
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [COL_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_top,
    output logic [DATA_W-1:0] o_mid
);

    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_lb2 [IMG_W];

    // Contents are never emitted before two full lines refill them, so the
    // storage carries no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_lb2[i_addr] <= r_lb1[i_addr];
            r_lb1[i_addr] <= i_data;
        end
    end

    assign o_top = r_lb2[i_addr];
    assign o_mid = r_lb1[i_addr];

endmodule

// File: rtl/conv3x3_stream_filter.sv
// ---------------------------------------------------------------------------
// conv3x3_stream_filter
// Streaming 3x3 Laplacian/sharpen filter for raster-order grayscale video
// with valid/ready handshakes, frame sync and output line/frame framing.
// Only interior centres are produced: output is (IMG_W-2)x(IMG_H-2).
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   i_cfg_mode  kernel select, latched when pixel (0,0) is accepted
//   i_in_valid  input pixel valid
//   o_in_ready  input accept (transfer = valid & ready)
//   i_in_data   input pixel
//   i_in_sof    first pixel of a frame; resyncs counters if seen elsewhere
//   o_out_valid output pixel valid
//   i_out_ready downstream accept
//   o_out_data  filtered pixel
//   o_out_eol   last output pixel of a line
//   o_out_eof   last output pixel of a frame
// ---------------------------------------------------------------------------
module conv3x3_stream_filter
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_cfg_mode,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_sof,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_eol,
    output logic              o_out_eof
);

    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_W   = $clog2(IMG_H);
    localparam int ACC_W   = DATA_W + ACC_GUARD_W;
    localparam int PIX_MAX = (1 << DATA_W) - 1;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    mode_e             r_mode;

    // Two previously accepted columns: "old" is c-2, "new" is c-1.
    logic [DATA_W-1:0] r_oldTop, r_oldMid, r_oldBot;
    logic [DATA_W-1:0] r_newTop, r_newMid, r_newBot;

    logic              w_accept;
    logic              w_resync;
    logic [COL_W-1:0]  w_effCol;
    logic [ROW_W-1:0]  w_effRow;
    logic              w_lastCol;
    logic              w_lastRow;
    logic              w_interior;
    logic [DATA_W-1:0] w_lbTop;
    logic [DATA_W-1:0] w_lbMid;

    logic signed [ACC_W-1:0] w_cExt;
    logic signed [ACC_W-1:0] w_n4;
    logic signed [ACC_W-1:0] w_n8;
    logic signed [ACC_W-1:0] w_acc;
    logic [DATA_W-1:0]       w_result;

    assign o_in_ready = !o_out_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    // A start-of-frame away from (0,0) makes this pixel (0,0) of a new frame.
    assign w_resync   = i_in_sof && ((r_col != '0) || (r_row != '0));
    assign w_effCol   = w_resync ? '0 : r_col;
    assign w_effRow   = w_resync ? '0 : r_row;
    assign w_lastCol  = (w_effCol == COL_W'(IMG_W - 1));
    assign w_lastRow  = (w_effRow == ROW_W'(IMG_H - 1));
    assign w_interior = (w_effRow >= ROW_W'(2)) && (w_effCol >= COL_W'(2));

    line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_lineBuffer (
        .clk    (clk),
        .i_we   (w_accept),
        .i_addr (w_effCol),
        .i_data (i_in_data),
        .o_top  (w_lbTop),
        .o_mid  (w_lbMid)
    );

    // Centre is (r-1,c-1) = r_newMid; the current taps form the right column.
    assign w_cExt = $signed({{ACC_GUARD_W{1'b0}}, r_newMid});
    assign w_n4   = $signed({{ACC_GUARD_W{1'b0}}, r_oldMid})
                  + $signed({{ACC_GUARD_W{1'b0}}, w_lbMid})
                  + $signed({{ACC_GUARD_W{1'b0}}, r_newTop})
                  + $signed({{ACC_GUARD_W{1'b0}}, r_newBot});
    assign w_n8   = w_n4
                  + $signed({{ACC_GUARD_W{1'b0}}, r_oldTop})
                  + $signed({{ACC_GUARD_W{1'b0}}, r_oldBot})
                  + $signed({{ACC_GUARD_W{1'b0}}, w_lbTop})
                  + $signed({{ACC_GUARD_W{1'b0}}, i_in_data});

    always_comb begin
        w_acc = '0;
        case (r_mode)
            MODE_LAP4:  w_acc = (w_cExt <<< 2) - w_n4;
            MODE_LAP8:  w_acc = (w_cExt <<< 3) - w_n8;
            MODE_SHARP: w_acc = (w_cExt <<< 2) + w_cExt - w_n4;
            MODE_ALAP4: w_acc = (w_cExt <<< 2) - w_n4;
            default:    w_acc = '0;
        endcase
    end

    assign w_result = DATA_W'(clampPixel(32'(w_acc), PIX_MAX, r_mode == MODE_ALAP4));

    // On resync the older column is cleared and the newer one takes this
    // pixel's column, so by c=2 both held columns belong to the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= MODE_LAP4;
            r_oldTop <= '0;
            r_oldMid <= '0;
            r_oldBot <= '0;
            r_newTop <= '0;
            r_newMid <= '0;
            r_newBot <= '0;
        end else if (w_accept) begin
            if ((w_effCol == '0) && (w_effRow == '0))
                r_mode <= mode_e'(i_cfg_mode);
            if (w_lastCol) begin
                r_col <= '0;
                r_row <= w_lastRow ? '0 : w_effRow + ROW_W'(1);
            end else begin
                r_col <= w_effCol + COL_W'(1);
                r_row <= w_effRow;
            end
            r_oldTop <= w_resync ? '0 : r_newTop;
            r_oldMid <= w_resync ? '0 : r_newMid;
            r_oldBot <= w_resync ? '0 : r_newBot;
            r_newTop <= w_lbTop;
            r_newMid <= w_lbMid;
            r_newBot <= i_in_data;
        end
    end

    // Single output register; a new load and a drain can coincide because
    // in_ready already requires the register to be empty or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_eol   <= 1'b0;
            o_out_eof   <= 1'b0;
        end else if (w_accept && w_interior) begin
            o_out_valid <= 1'b1;
            o_out_data  <= w_result;
            o_out_eol   <= w_lastCol;
            o_out_eof   <= w_lastCol && w_lastRow;
        end else if (o_out_valid && i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end

endmodule
